pc_mem_unit: RTL and testbench

Datapath front-end of the multicycle MIPS core, directly downstream of the main control decoder. It consumes the decoder's IorD, IRwrite, memwrite, pcwrite, branch and pcsrc outputs. It owns the PC, instruction register (IR) and memory data register (MDR), and runs the single unified-memory port through a ready/request handshake. It returns op = IR[31:26] to the decoder, plus a stall that freezes the decoder's state while memory is busy.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/pc_mem_unit_flopenr.sv | 23 ++
 rtl/pc_mem_unit.sv | 128 ++++++++++++
 tb/tb_pc_mem_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS datapath front-end.
//   pcsrc_t : PC next-value source select (matches the decoder's pcsrc encoding)
//   memst_t : memory-port handshake states
//   OP_*    : primary opcodes as seen on op = instr[31:26]
package mips_pkg;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pcsrc_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memst_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/pc_mem_unit_flopenr.sv
// Enable register with synchronous active-low reset.
//   clk   : clock
//   reset : synchronous, active-low; loads RESETVAL
//   en    : load d when high
//   d     : next value
//   q     : registered value
module flopenr #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESETVAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)  q <= RESETVAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pc_mem_unit.sv
// Datapath front-end of the multicycle MIPS core: owns PC, IR and MDR and runs
// the unified memory port through a request/ready handshake.
//   clk, reset                 : clock, synchronous active-low reset
//   IorD, IRwrite, memwrite    : access requests from the decoder
//   pcwrite, branch, pcsrc     : PC update controls; zero is the ALU zero flag
//   aluresult, aluout, regb    : ALU result (comb), ALU result (reg), store data
//   mem_req/we/addr/wdata      : registered memory request
//   mem_ready, mem_rdata       : memory completion and read data
//   pc, instr, op, mdr         : architectural registers; op = instr[31:26]
//   stall                      : decoder must hold its state this cycle
module pc_mem_unit
  import mips_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IorD,
  input  logic             IRwrite,
  input  logic             memwrite,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic [1:0]       pcsrc,
  input  logic             zero,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] aluout,
  input  logic [WIDTH-1:0] regb,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [WIDTH-1:0] mdr,
  output logic             stall
);

  memst_t           state;
  logic             access;
  logic             tgt_ir;
  logic             done;
  logic             ir_en;
  logic             mdr_en;
  logic             pcen;
  logic [WIDTH-1:0] addr_sel;
  logic [WIDTH-1:0] pcnext;

  assign access   = IRwrite | IorD | memwrite;
  assign addr_sel = IorD ? aluout : pc;

  // Address, data and read target are captured in IDLE so the bus stays
  // stable for the whole BUSY phase regardless of the decoder's outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tgt_ir    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_addr  <= {addr_sel[WIDTH-1:2], 2'b00};
            mem_wdata <= regb;
            mem_we    <= memwrite;
            // IRwrite with memwrite is treated as a plain write.
            tgt_ir    <= IRwrite & ~memwrite;
            mem_req   <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = access;
    else               stall = ~mem_ready;
  end

  assign done   = (state == BUSY) & mem_ready;
  assign ir_en  = done & ~mem_we & tgt_ir;
  assign mdr_en = done & ~mem_we & ~tgt_ir;

  assign pcen = (pcwrite | (branch & zero)) & ~stall;

  // Jump target uses the current IR, which is stable outside a fetch.
  always_comb begin
    pcnext = pc;
    case (pcsrc_t'(pcsrc))
      PC_ALU:    pcnext = aluresult;
      PC_ALUOUT: pcnext = aluout;
      PC_JUMP:   pcnext = {pc[WIDTH-1:28], instr[25:0], 2'b00};
      PC_HOLD:   pcnext = pc;
      default:   pcnext = pc;
    endcase
  end

  flopenr #(.WIDTH(WIDTH), .RESETVAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pcen), .d(pcnext), .q(pc)
  );

  flopenr #(.WIDTH(WIDTH), .RESETVAL('0)) u_ir (
    .clk(clk), .reset(reset), .en(ir_en), .d(mem_rdata), .q(instr)
  );

  flopenr #(.WIDTH(WIDTH), .RESETVAL('0)) u_mdr (
    .clk(clk), .reset(reset), .en(mdr_en), .d(mem_rdata), .q(mdr)
  );

  assign op = instr[31:26];

endmodule

// File: tb/tb_pc_mem_unit.sv
module tb_pc_mem_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        IorD, IRwrite, memwrite, pcwrite, branch, zero;
  logic [1:0]  pcsrc;
  logic [31:0] aluresult, aluout, regb;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc, instr, mdr;
  logic [5:0]  op;
  logic        stall;

  int total = 0;
  int bad   = 0;

  // Reference architectural state.
  logic [31:0] m_pc, m_instr, m_mdr;

  pc_mem_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .IorD(IorD), .IRwrite(IRwrite), .memwrite(memwrite),
    .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .zero(zero),
    .aluresult(aluresult), .aluout(aluout), .regb(regb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr), .op(op), .mdr(mdr), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [1:0] ps, input logic [31:0] ares,
                                          input logic [31:0] aout);
    case (ps)
      2'd0:    return ares;
      2'd1:    return aout;
      2'd2:    return {m_pc[31:28], m_instr[25:0], 2'b00};
      default: return m_pc;
    endcase
  endfunction

  task automatic idle_inputs();
    IorD = 0; IRwrite = 0; memwrite = 0; pcwrite = 0; branch = 0; zero = 0;
    pcsrc = 2'd3;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".op"}, {26'b0, op}, {26'b0, m_instr[31:26]});
    chk({tag, ".mdr"}, mdr, m_mdr);
  endtask

  // PC update with no memory access: takes effect at the next edge.
  task automatic pc_only(input string tag, input logic pcw, input logic br, input logic z,
                         input logic [1:0] ps, input logic [31:0] ares, input logic [31:0] aout);
    idle_inputs();
    pcwrite = pcw; branch = br; zero = z; pcsrc = ps; aluresult = ares; aluout = aout;
    mem_ready = 1'($urandom);
    #1;
    chk({tag, ".stall"}, {31'b0, stall}, 32'd0);
    if (pcw | (br & z)) m_pc = next_pc(ps, ares, aout);
    step();
    idle_inputs();
    mem_ready = 0;
    #1;
    check_regs(tag);
    chk({tag, ".req"}, {31'b0, mem_req}, 32'd0);
  endtask

  // One memory transaction with 'waits' not-ready BUSY cycles.
  task automatic access(input string tag, input logic iord, input logic irw, input logic mw,
                        input logic pcw, input logic br, input logic z, input logic [1:0] ps,
                        input logic [31:0] ares, input logic [31:0] aout, input logic [31:0] rb,
                        input logic [31:0] rdata, input int waits);
    logic [31:0] exp_addr;
    idle_inputs();
    IorD = iord; IRwrite = irw; memwrite = mw; pcwrite = pcw; branch = br; zero = z;
    pcsrc = ps; aluresult = ares; aluout = aout; regb = rb;
    mem_ready = 1'($urandom);   // ignored while idle
    mem_rdata = $urandom;
    exp_addr = iord ? aout : m_pc;
    exp_addr[1:0] = 2'b00;
    #1;
    chk({tag, ".idle_stall"}, {31'b0, stall}, 32'd1);
    chk({tag, ".idle_req"}, {31'b0, mem_req}, 32'd0);
    step();
    for (int i = 0; i < waits; i++) begin
      mem_ready = 0;
      #1;
      chk({tag, ".wait_stall"}, {31'b0, stall}, 32'd1);
      chk({tag, ".wait_req"}, {31'b0, mem_req}, 32'd1);
      chk({tag, ".wait_addr"}, mem_addr, exp_addr);
      chk({tag, ".wait_pc"}, pc, m_pc);
      chk({tag, ".wait_instr"}, instr, m_instr);
      step();
    end
    mem_ready = 1; mem_rdata = rdata;
    #1;
    chk({tag, ".rdy_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, ".rdy_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, ".rdy_we"}, {31'b0, mem_we}, {31'b0, mw});
    chk({tag, ".rdy_addr"}, mem_addr, exp_addr);
    if (mw) chk({tag, ".rdy_wdata"}, mem_wdata, rb);
    // Model: PC update and read capture both happen at the completion edge.
    if (pcw | (br & z)) m_pc = next_pc(ps, ares, aout);
    if (!mw) begin
      if (irw) m_instr = rdata;
      else     m_mdr   = rdata;
    end
    step();
    idle_inputs();
    mem_ready = 0;
    #1;
    check_regs(tag);
    chk({tag, ".end_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, ".end_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, ".end_stall"}, {31'b0, stall}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    aluresult = 0; aluout = 0; regb = 0; mem_rdata = 32'hFFFF_FFFF;
    reset = 0; mem_ready = 1;
    m_pc = RESET_PC; m_instr = 0; m_mdr = 0;

    // Reset held for two cycles with mem_ready high.
    step(); step();
    check_regs("reset");
    chk("reset.req", {31'b0, mem_req}, 32'd0);
    chk("reset.we", {31'b0, mem_we}, 32'd0);
    chk("reset.addr", mem_addr, 32'd0);
    chk("reset.wdata", mem_wdata, 32'd0);
    chk("reset.stall", {31'b0, stall}, 32'd0);
    reset = 1; mem_ready = 0;
    step();

    // Zero-wait and wait-state fetches.
    pc_only("setpc", 1, 0, 0, 2'd0, 32'h0040_0000, 32'h0);
    access("fetch0", 0, 1, 0, 1, 0, 0, 2'd0, 32'h0040_0004, 32'h0, 32'h0, 32'h8C09_0004, 0);
    chk("fetch0.op_lw", {26'b0, op}, 32'h23);
    chk("fetch0.pc", pc, 32'h0040_0004);
    access("fetch3", 0, 1, 0, 1, 0, 0, 2'd0, 32'h0040_0008, 32'h0, 32'h0, 32'hAC0A_0008, 3);

    // Load and store.
    access("lw", 1, 0, 0, 0, 0, 0, 2'd3, 32'h0, 32'h0000_1003, 32'h0, 32'hDEAD_BEEF, 1);
    chk("lw.mdr", mdr, 32'hDEAD_BEEF);
    access("sw", 1, 0, 1, 0, 0, 0, 2'd3, 32'h0, 32'h0000_2002, 32'h1234_5678, 32'h5555_5555, 0);
    // Illegal IRwrite+memwrite behaves as a write; IR untouched.
    access("irw_mw", 0, 1, 1, 0, 0, 0, 2'd3, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h7777_7777, 2);

    // Branch taken / not taken, and jump.
    pc_only("beq_t", 0, 1, 1, 2'd1, 32'h0, 32'h0000_0040);
    chk("beq_t.pc40", pc, 32'h0000_0040);
    pc_only("beq_nt", 0, 1, 0, 2'd1, 32'h0, 32'h0000_0080);
    access("fetchj", 0, 1, 0, 1, 0, 0, 2'd0, 32'h0040_0010, 32'h0, 32'h0, 32'h0810_0005, 0);
    pc_only("jump", 1, 0, 0, 2'd2, 32'h0, 32'h0);
    chk("jump.pc", pc, 32'h0040_0014);
    pc_only("wrap", 1, 0, 0, 2'd0, 32'hFFFF_FFFC, 32'h0);
    access("wrapf", 0, 1, 0, 1, 0, 0, 2'd0, 32'h0000_0000, 32'h0, 32'h0, 32'h2008_0001, 0);

    // Reset in the middle of an access; a late ready must be ignored.
    IRwrite = 1; pcwrite = 1; pcsrc = 2'd0; aluresult = 32'h0000_0104;
    #1;
    step();
    chk("rstmid.busy_req", {31'b0, mem_req}, 32'd1);
    reset = 0;
    step();
    idle_inputs();
    reset = 1; mem_ready = 1; mem_rdata = 32'h1111_2222;
    m_pc = RESET_PC; m_instr = 0; m_mdr = 0;
    #1;
    chk("rstmid.req", {31'b0, mem_req}, 32'd0);
    chk("rstmid.stall", {31'b0, stall}, 32'd0);
    step();
    mem_ready = 0;
    #1;
    check_regs("rstmid");
    chk("rstmid.req2", {31'b0, mem_req}, 32'd0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic iord, irw, mw, pcw, br, z;
      logic [1:0] ps;
      iord = 1'($urandom); irw = 1'($urandom); mw = 1'($urandom);
      pcw = 1'($urandom); br = 1'($urandom); z = 1'($urandom);
      ps = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        iord = 0; irw = 0; mw = 0;
      end
      if (!(iord | irw | mw))
        pc_only("rnd_pc", pcw, br, z, ps, $urandom, $urandom);
      else
        access("rnd_acc", iord, irw, mw, pcw, br, z, ps, $urandom, $urandom, $urandom,
               $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
